// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack controller: default widths, opcodes and FSM states.
package rpn_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        OP_PUSH  = 3'b000,
        OP_POP   = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_DUP   = 3'b100,
        OP_SWAP  = 3'b101,
        OP_CLEAR = 3'b110,
        OP_NOP   = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_EXEC = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational NOS op TOS arithmetic; results wrap modulo 2^DATA_W.
module rpn_alu #(
    parameter int DATA_W = rpn_pkg::DATA_W_DEF
) (
    input  logic [DATA_W-1:0] nos,
    input  logic [DATA_W-1:0] tos,
    input  logic              sub,
    output logic [DATA_W-1:0] result
);

    assign result = sub ? (nos - tos) : (nos + tos);

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN stack controller: TOS held in a register, lower entries in an external
// single-port RAM with one-cycle registered read.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WR    | RAM write (PUSH/DUP spill TOS to mem[sp], SWAP writes old TOS to mem[sp-1])
// RD    | RAM read address sp-1 presented
// EXEC  | mem_rdata valid: POP/ADD/SUB update TOS, SWAP latches NOS
// DONE  | single-cycle completion with no RAM access (errors, trivial ops)
module rpn_stack_ctrl
    import rpn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cmd_ready,
    output logic              done,
    output logic              err_ovf,
    output logic              err_unf,
    output logic              err_sticky,
    output logic [DATA_W-1:0] tos,
    output logic [ADDR_W:0]   depth,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] DEPTH_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    op_e               op_q;
    op_e               op_in;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] tos_q;
    logic [DATA_W-1:0] nos_q;
    logic [ADDR_W:0]   depth_q;
    logic              eovf_q, eunf_q, sticky_q;
    logic              ovf_chk, unf_chk;
    logic [ADDR_W-1:0] sp;
    logic [DATA_W-1:0] alu_y;
    logic              accept;

    assign op_in  = op_e'(cmd_op);
    assign sp     = depth_q[ADDR_W-1:0] - ADDR_W'(1);
    assign accept = cmd_valid && (state_q == ST_IDLE);

    always_comb begin
        ovf_chk = 1'b0;
        unf_chk = 1'b0;
        case (op_in)
            OP_PUSH:         ovf_chk = (depth_q == DEPTH_FULL);
            OP_DUP: begin
                ovf_chk = (depth_q == DEPTH_FULL);
                unf_chk = (depth_q == '0);
            end
            OP_POP:          unf_chk = (depth_q == '0);
            OP_ADD, OP_SUB,
            OP_SWAP:         unf_chk = (depth_q < (ADDR_W+1)'(2));
            default: begin
                ovf_chk = 1'b0;
                unf_chk = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (ovf_chk || unf_chk) begin
                        state_d = ST_DONE;
                    end else begin
                        case (op_in)
                            OP_PUSH: state_d = (depth_q == '0) ? ST_DONE : ST_WR;
                            OP_POP:  state_d = (depth_q == (ADDR_W+1)'(1)) ? ST_DONE : ST_RD;
                            OP_ADD, OP_SUB, OP_SWAP: state_d = ST_RD;
                            OP_DUP:  state_d = ST_WR;
                            default: state_d = ST_DONE;
                        endcase
                    end
                end
            end
            ST_RD:   state_d = ST_EXEC;
            ST_EXEC: state_d = (op_q == OP_SWAP) ? ST_WR : ST_IDLE;
            ST_WR:   state_d = ST_IDLE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    rpn_alu #(.DATA_W(DATA_W)) u_alu (
        .nos    (mem_rdata),
        .tos    (tos_q),
        .sub    (op_q == OP_SUB),
        .result (alu_y)
    );

    // Stack state commits on the final cycle of each command so an aborted
    // command leaves nothing half-applied.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            op_q     <= OP_NOP;
            data_q   <= '0;
            eovf_q   <= 1'b0;
            eunf_q   <= 1'b0;
            tos_q    <= '0;
            nos_q    <= '0;
            depth_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= op_in;
                        data_q <= cmd_data;
                        eovf_q <= ovf_chk;
                        eunf_q <= unf_chk;
                    end
                end
                ST_DONE: begin
                    if (eovf_q || eunf_q) begin
                        sticky_q <= 1'b1;
                    end else begin
                        case (op_q)
                            OP_PUSH: begin
                                tos_q   <= data_q;
                                depth_q <= (ADDR_W+1)'(1);
                            end
                            OP_POP: begin
                                tos_q   <= '0;
                                depth_q <= '0;
                            end
                            OP_CLEAR: begin
                                tos_q    <= '0;
                                depth_q  <= '0;
                                sticky_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    case (op_q)
                        OP_POP: begin
                            tos_q   <= mem_rdata;
                            depth_q <= depth_q - (ADDR_W+1)'(1);
                        end
                        OP_ADD, OP_SUB: begin
                            tos_q   <= alu_y;
                            depth_q <= depth_q - (ADDR_W+1)'(1);
                        end
                        OP_SWAP: nos_q <= mem_rdata;
                        default: ;
                    endcase
                end
                ST_WR: begin
                    case (op_q)
                        OP_PUSH: begin
                            tos_q   <= data_q;
                            depth_q <= depth_q + (ADDR_W+1)'(1);
                        end
                        OP_DUP:  depth_q <= depth_q + (ADDR_W+1)'(1);
                        OP_SWAP: tos_q <= nos_q;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        done      = (state_q == ST_DONE) || (state_q == ST_WR) ||
                    ((state_q == ST_EXEC) && (op_q != OP_SWAP));
        err_ovf   = (state_q == ST_DONE) && eovf_q;
        err_unf   = (state_q == ST_DONE) && eunf_q;
        mem_we    = (state_q == ST_WR);
        mem_wdata = tos_q;
        // SWAP writes back into the NOS slot; PUSH/DUP spill into the free slot.
        mem_addr  = ((state_q == ST_WR) && (op_q != OP_SWAP)) ? sp : (sp - ADDR_W'(1));
    end

    assign tos        = tos_q;
    assign depth      = depth_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed self-checking bench for rpn_stack_ctrl with a 4-entry stack.
module tb_rpn_stack_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;

    localparam logic [2:0] PUSH = 3'b000, POP = 3'b001, ADD = 3'b010, SUB = 3'b011,
                           DUP = 3'b100, SWAP = 3'b101, CLR = 3'b110, NOP = 3'b111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_op = 3'b111;
    logic [DW-1:0] cmd_data = '0;
    logic          cmd_ready, done, err_ovf, err_unf, err_sticky, mem_we;
    logic [DW-1:0] tos, mem_wdata, mem_rdata;
    logic [AW:0]   depth;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rpn_stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .done       (done),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf),
        .err_sticky (err_sticky),
        .tos        (tos),
        .depth      (depth),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic do_reset();
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issues one command from a negedge; lat = cycles from acceptance edge to done (99 on timeout).
    task automatic issue(input logic [2:0] op, input logic [DW-1:0] d, output int lat,
                         output logic eo, output logic eu, output logic we_seen);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        eo = 1'b0;
        eu = 1'b0;
        we_seen = 1'b0;
        while (!done && lat < 10) begin
            we_seen |= mem_we;
            @(negedge clk);
            lat++;
        end
        we_seen |= mem_we;
        eo = err_ovf;
        eu = err_unf;
        if (!done) lat = 99;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (tos !== 8'h00 || depth !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: tos=%h depth=%0d, expected tos=00 depth=0", tos, depth);
        end
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || err_sticky !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b done=%b sticky=%b we=%b, expected 1 0 0 0",
                     cmd_ready, done, err_sticky, mem_we);
        end
    endtask

    task automatic test_add();
        int lat;
        logic eo, eu, we;
        do_reset();
        issue(PUSH, 8'd5, lat, eo, eu, we);
        checks++;
        if (lat !== 1 || tos !== 8'd5) begin
            errors++;
            $display("FAIL push_empty: lat=%0d tos=%h, expected lat=1 tos=05", lat, tos);
        end
        issue(PUSH, 8'd3, lat, eo, eu, we);
        checks++;
        if (lat !== 1 || we !== 1'b1 || depth !== 3'd2) begin
            errors++;
            $display("FAIL push_spill: lat=%0d we=%b depth=%0d, expected 1 1 2", lat, we, depth);
        end
        issue(ADD, 8'd0, lat, eo, eu, we);
        checks++;
        if (lat !== 2 || tos !== 8'd8 || depth !== 3'd1) begin
            errors++;
            $display("FAIL add: lat=%0d tos=%h depth=%0d, expected lat=2 tos=08 depth=1", lat, tos, depth);
        end
    endtask

    task automatic test_sub_underflow();
        int lat;
        logic eo, eu, we;
        do_reset();
        issue(PUSH, 8'd2, lat, eo, eu, we);
        issue(PUSH, 8'd7, lat, eo, eu, we);
        issue(SUB, 8'd0, lat, eo, eu, we);
        checks++;
        if (lat !== 2 || tos !== 8'hFB || depth !== 3'd1) begin
            errors++;
            $display("FAIL sub: lat=%0d tos=%h depth=%0d, expected lat=2 tos=fb depth=1", lat, tos, depth);
        end
        issue(SWAP, 8'd0, lat, eo, eu, we);
        checks++;
        if (eu !== 1'b1 || eo !== 1'b0 || lat !== 1 || we !== 1'b0) begin
            errors++;
            $display("FAIL swap_unf_pulse: unf=%b ovf=%b lat=%0d we=%b, expected 1 0 1 0", eu, eo, lat, we);
        end
        checks++;
        if (err_sticky !== 1'b1 || tos !== 8'hFB || depth !== 3'd1) begin
            errors++;
            $display("FAIL swap_unf_state: sticky=%b tos=%h depth=%0d, expected 1 fb 1", err_sticky, tos, depth);
        end
    endtask

    task automatic test_swap_pop();
        int lat;
        logic eo, eu, we;
        do_reset();
        issue(PUSH, 8'hAA, lat, eo, eu, we);
        issue(PUSH, 8'h55, lat, eo, eu, we);
        issue(SWAP, 8'd0, lat, eo, eu, we);
        checks++;
        if (lat !== 3 || tos !== 8'hAA || depth !== 3'd2 || we !== 1'b1) begin
            errors++;
            $display("FAIL swap: lat=%0d tos=%h depth=%0d we=%b, expected 3 aa 2 1", lat, tos, depth, we);
        end
        issue(POP, 8'd0, lat, eo, eu, we);
        checks++;
        if (lat !== 2 || tos !== 8'h55 || depth !== 3'd1) begin
            errors++;
            $display("FAIL pop: lat=%0d tos=%h depth=%0d, expected 2 55 1", lat, tos, depth);
        end
        issue(POP, 8'd0, lat, eo, eu, we);
        checks++;
        if (lat !== 1 || tos !== 8'h00 || depth !== 3'd0) begin
            errors++;
            $display("FAIL pop_last: lat=%0d tos=%h depth=%0d, expected 1 00 0", lat, tos, depth);
        end
        issue(POP, 8'd0, lat, eo, eu, we);
        checks++;
        if (eu !== 1'b1 || depth !== 3'd0 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL pop_empty: unf=%b depth=%0d sticky=%b, expected 1 0 1", eu, depth, err_sticky);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic eo, eu, we;
        do_reset();
        for (int i = 1; i <= 4; i++) issue(PUSH, DW'(i), lat, eo, eu, we);
        checks++;
        if (tos !== 8'd4 || depth !== 3'd4) begin
            errors++;
            $display("FAIL fill: tos=%h depth=%0d, expected 04 4", tos, depth);
        end
        issue(PUSH, 8'd9, lat, eo, eu, we);
        checks++;
        if (eo !== 1'b1 || we !== 1'b0 || depth !== 3'd4 || tos !== 8'd4) begin
            errors++;
            $display("FAIL push_ovf: ovf=%b we=%b depth=%0d tos=%h, expected 1 0 4 04", eo, we, depth, tos);
        end
        issue(DUP, 8'd0, lat, eo, eu, we);
        checks++;
        if (eo !== 1'b1 || we !== 1'b0 || depth !== 3'd4 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL dup_ovf: ovf=%b we=%b depth=%0d sticky=%b, expected 1 0 4 1", eo, we, depth, err_sticky);
        end
        issue(CLR, 8'd0, lat, eo, eu, we);
        checks++;
        if (lat !== 1 || depth !== 3'd0 || tos !== 8'd0 || err_sticky !== 1'b0 || we !== 1'b0) begin
            errors++;
            $display("FAIL clear: lat=%0d depth=%0d tos=%h sticky=%b we=%b, expected 1 0 00 0 0",
                     lat, depth, tos, err_sticky, we);
        end
        issue(PUSH, 8'd6, lat, eo, eu, we);
        issue(DUP, 8'd0, lat, eo, eu, we);
        checks++;
        if (lat !== 1 || tos !== 8'd6 || depth !== 3'd2) begin
            errors++;
            $display("FAIL dup: lat=%0d tos=%h depth=%0d, expected 1 06 2", lat, tos, depth);
        end
        issue(NOP, 8'd0, lat, eo, eu, we);
        checks++;
        if (lat !== 1 || tos !== 8'd6 || depth !== 3'd2 || we !== 1'b0) begin
            errors++;
            $display("FAIL nop: lat=%0d tos=%h depth=%0d we=%b, expected 1 06 2 0", lat, tos, depth, we);
        end
        issue(ADD, 8'd0, lat, eo, eu, we);
        checks++;
        if (tos !== 8'h0C || depth !== 3'd1) begin
            errors++;
            $display("FAIL dup_add: tos=%h depth=%0d, expected 0c 1", tos, depth);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int dn;
        logic eo, eu, we;
        do_reset();
        issue(PUSH, 8'd5, lat, eo, eu, we);
        issue(PUSH, 8'd3, lat, eo, eu, we);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || tos !== 8'd0 || depth !== 3'd0) begin
            errors++;
            $display("FAIL abort_in_reset: done=%b tos=%h depth=%0d, expected 0 00 0", done, tos, depth);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++;
        if (dn !== 0 || cmd_ready !== 1'b1 || tos !== 8'd0 || depth !== 3'd0) begin
            errors++;
            $display("FAIL abort_after: done_pulses=%0d ready=%b tos=%h depth=%0d, expected 0 1 00 0",
                     dn, cmd_ready, tos, depth);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int dn;
        do_reset();
        acc = 0;
        dn = 0;
        cmd_op = PUSH;
        for (int i = 0; i < 14; i++) begin
            if (done) dn++;
            if (cmd_ready) begin
                if (acc < 4) begin
                    cmd_valid = 1'b1;
                    cmd_data  = DW'(acc + 1);
                    acc++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (dn !== 4 || acc !== 4) begin
            errors++;
            $display("FAIL b2b_count: done_pulses=%0d accepts=%0d, expected 4 4", dn, acc);
        end
        checks++;
        if (tos !== 8'd4 || depth !== 3'd4) begin
            errors++;
            $display("FAIL b2b_state: tos=%h depth=%0d, expected 04 4", tos, depth);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_underflow();
        test_swap_pop();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
